// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_PORTS = 2;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SETUP,
    ST_READ_REQ,
    ST_READ_REL,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ram_ack_sync.sv
// Multi-flop synchroniser bringing the RAM's asynchronous ack into the clock domain.
module ram_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  assign sync_d[0] = async_in;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a req/ack handshake RAM (port 0 CPU, port 1 loader).
// Define RAM_ARB_FIXED_PRIORITY_EN to make port 0 always win contention instead of round robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 8,
  parameter int WRITE_PULSE_CYCLES = 1,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [NUM_PORTS-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] address [NUM_PORTS],
  input  logic [DATA_WIDTH-1:0] wdata   [NUM_PORTS],
  output logic [NUM_PORTS-1:0]  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_req,
  input  logic                  ram_ack
);

  localparam int CNT_W = $clog2(WRITE_PULSE_CYCLES + 1);

  state_t                state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ram_write_q, ram_write_d;
  logic                  ram_req_q, ram_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  ram_ack_s;
  logic                  sel;

  ram_ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_in(ram_ack),
    .sync_out(ram_ack_s)
  );

  // Port choice made in IDLE; only meaningful when some req is high.
  always_comb begin
    sel = PORT_CPU;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    sel = req[PORT_CPU] ? PORT_CPU : PORT_LOADER;
`else
    if (req[PORT_CPU] && req[PORT_LOADER]) begin
      sel = ~last_grant_q;
    end else begin
      sel = req[PORT_CPU] ? PORT_CPU : PORT_LOADER;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    ram_write_d  = ram_write_q;
    ram_req_d    = ram_req_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    data_in_d    = data_in_q;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          port_d       = sel;
          we_d         = we[sel];
          addr_d       = address[sel];
          wdata_d      = wdata[sel];
          last_grant_d = sel;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (we_q) begin
          wr_addr_d = addr_q;
          data_in_d = wdata_q;
        end else begin
          rd_addr_d = addr_q;
        end
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (we_q) begin
          ram_write_d = 1'b1;
          cnt_d       = CNT_W'(WRITE_PULSE_CYCLES - 1);
          state_d     = ST_WR_PULSE;
        end else begin
          ram_req_d = 1'b1;
          state_d   = ST_READ_REQ;
        end
      end
      ST_READ_REQ: begin
        if (ram_ack_s) begin
          rdata_d   = ram_data_out;
          ram_req_d = 1'b0;
          state_d   = ST_READ_REL;
        end
      end
      ST_READ_REL: begin
        if (!ram_ack_s) begin
          ack_d[port_q] = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          ram_write_d = 1'b0;
          state_d     = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        ack_d[port_q] = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        // A requester holding req keeps this transaction open; no re-issue.
        if (!req[port_q]) begin
          ack_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= PORT_LOADER;
      cnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      ram_write_q  <= 1'b0;
      ram_req_q    <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      data_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      ram_write_q  <= ram_write_d;
      ram_req_q    <= ram_req_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      data_in_q    <= data_in_d;
    end
  end

  assign ack               = ack_q;
  assign rdata             = rdata_q;
  assign ram_write         = ram_write_q;
  assign ram_req           = ram_req_q;
  assign ram_write_address = wr_addr_q;
  assign ram_read_address  = rd_addr_q;
  assign ram_data_in       = data_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural handshake RAM and configurable ack delay.
module tb_ram_arbiter;

  logic       clock;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] address [2];
  logic [7:0] wdata   [2];
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       ram_write;
  logic [7:0] ram_write_address;
  logic [7:0] ram_read_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic       ram_req;
  logic       ram_ack;

  ram_arbiter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .WRITE_PULSE_CYCLES(1), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we),
    .address(address), .wdata(wdata), .ack(ack), .rdata(rdata),
    .ram_write(ram_write), .ram_write_address(ram_write_address),
    .ram_read_address(ram_read_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_req(ram_req), .ram_ack(ram_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: stores on ram_write rising edge, ack follows req after ack_delay cycles
  logic [7:0] mem [256];
  logic [7:0] req_hist;
  int         ack_delay = 0;
  always @(posedge ram_write) mem[ram_write_address] <= ram_data_in;
  assign ram_data_out = mem[ram_read_address];
  always @(posedge clock) req_hist <= {req_hist[6:0], ram_req};
  always_comb begin
    ram_ack = ram_req;
    if (ack_delay > 0) ram_ack = req_hist[ack_delay-1];
  end

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   order_q[$];

  task automatic check(input string name, input int act, input int req_v);
    tests++;
    if (act != req_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
    end
  endtask

  // Monitor: pops per-port expectations on each ack rising edge
  logic [1:0] ack_prev = 2'b00;
  int ack_len [2] = '{0, 0};
  int last_ack_len [2] = '{0, 0};
  int wr_cnt = 0, last_wr_len = 0, ram_req_rises = 0;
  logic [7:0] wr_addr_s, wr_data_s;
  logic wr_unstable = 1'b0, ram_req_prev = 1'b0;

  always @(negedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (ack[p] && !ack_prev[p]) begin
        exp_t e;
        int   sz;
        sz = (p == 0) ? exp_q0.size() : exp_q1.size();
        check("ack_onehot", int'(ack), (p == 0) ? 1 : 2);
        if (sz == 0) begin
          check("unexpected_ack_port", p, -1);
        end else begin
          e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (e.rd) check("rdata", int'(rdata), int'(e.data));
          if (e.exp_cyc >= 0) check("ack_latency_cycle", cyc, e.exp_cyc);
          $display("[TB] ack port %0d cyc %0d rd %0b rdata 0x%02h", p, cyc, e.rd, rdata);
        end
        if (order_q.size() > 0) check("grant_order", p, order_q.pop_front());
      end
      if (ack[p]) ack_len[p]++;
      else if (ack_prev[p]) begin
        last_ack_len[p] = ack_len[p];
        ack_len[p] = 0;
      end
    end
    ack_prev = ack;
    if (ram_write) begin
      if (wr_cnt == 0) begin
        wr_addr_s = ram_write_address;
        wr_data_s = ram_data_in;
      end else if (wr_addr_s != ram_write_address || wr_data_s != ram_data_in) begin
        wr_unstable = 1'b1;
      end
      wr_cnt++;
    end else if (wr_cnt > 0) begin
      last_wr_len = wr_cnt;
      wr_cnt = 0;
    end
    if (ram_req && !ram_req_prev) ram_req_rises++;
    ram_req_prev = ram_req;
  end

  // Issues one transaction; called at a negedge, returns one negedge after dropping req
  task automatic do_txn(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input int lat);
    exp_t e;
    int   n;
    we[p] = w; address[p] = a; wdata[p] = d;
    e.rd = !w; e.data = exp_rd;
    e.exp_cyc = (lat < 0) ? -1 : cyc + 1 + lat;
    if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    req[p] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ack[p] && n < 400);
    check("ack_timeout", int'(ack[p]), 1);
    req[p] = 1'b0;
    @(negedge clock);
  endtask

  int rises0;
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    req = 2'b00; we = 2'b00;
    address[0] = 8'h00; address[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ack", int'(ack), 0);
    check("reset_ram_write", int'(ram_write), 0);
    check("reset_ram_req", int'(ram_req), 0);
    check("reset_rdata", int'(rdata), 0);
    check("reset_addrs", int'({ram_write_address, ram_read_address, ram_data_in}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Port 0 write 0xA5 -> 0x10
    do_txn(0, 1'b1, 8'h10, 8'hA5, 8'h00, 4);
    check("wr_pulse_len", last_wr_len, 1);
    check("wr_pulse_addr", int'(wr_addr_s), 'h10);
    check("wr_pulse_data", int'(wr_data_s), 'hA5);
    check("wr_stable", int'(wr_unstable), 0);
    check("ram_mem_10", int'(mem[8'h10]), 'hA5);

    // Port 1 read back
    rises0 = ram_req_rises;
    do_txn(1, 1'b0, 8'h10, 8'h00, 8'hA5, 8);
    check("rd_ram_req_pulses", ram_req_rises - rises0, 1);

    // Port 1 write 0x3C -> 0x20 (leaves last grant on port 1)
    do_txn(1, 1'b1, 8'h20, 8'h3C, 8'h00, 4);
    check("ram_mem_20", int'(mem[8'h20]), 'h3C);

    // Contention: both ports issue four back-to-back reads
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    order_q = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    order_q = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    fork
      for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, -1);
      for (int j = 0; j < 4; j++) do_txn(1, 1'b0, 8'h20, 8'h00, 8'h3C, -1);
    join
    check("order_consumed", order_q.size(), 0);

    // Port 0 drops req two cycles into a read
    begin
      exp_t e;
      we[0] = 1'b0; address[0] = 8'h20;
      e.rd = 1'b1; e.data = 8'h3C; e.exp_cyc = cyc + 1 + 8;
      exp_q0.push_back(e);
      req[0] = 1'b1;
      repeat (2) @(negedge clock);
      req[0] = 1'b0;
      n = 0;
      while (!ack[0] && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("drop_ack_seen", int'(ack[0]), 1);
      @(negedge clock);
      check("drop_ack_low", int'(ack[0]), 0);
      @(negedge clock);
      check("drop_ack_len", last_ack_len[0], 1);
    end

    // Reset during READ_REQ
    we[1] = 1'b0; address[1] = 8'h10; req[1] = 1'b1;
    n = 0;
    while (!ram_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("rst_reached_read_req", int'(ram_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ram_req", int'(ram_req), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_rdata", int'(rdata), 0);
    req[1] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_txn(1, 1'b0, 8'h10, 8'h00, 8'hA5, 8);

    // Slow RAM: ack delayed by 5 cycles each way
    ack_delay = 5;
    rises0 = ram_req_rises;
    do_txn(1, 1'b0, 8'h20, 8'h00, 8'h3C, 18);
    check("slow_ram_req_pulses", ram_req_rises - rises0, 1);
    ack_delay = 0;

    repeat (3) @(negedge clock);
    check("exp_q0_empty", exp_q0.size(), 0);
    check("exp_q1_empty", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Clocked sequencer that shares one handshake-driven RAM between two requesters: port 0 is the MC14500B data path, port 1 is the loader/debug port. It accepts four-phase req/ack transactions from each port and arbitrates between them. It drives the RAM's write strobe, addresses, data and req_prev. It synchronises the RAM's ack_prev back into the clock domain and returns read data.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 8, RAM address width
WRITE_PULSE_CYCLES, 1, cycles ram_write is held high (>=1)
SYNC_STAGES, 2, flops in the ram_ack synchroniser (>=2)

Ports:
clock  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
req[1:0]  in  2  per-port transaction request (four-phase)
we[1:0]  in  2  per-port write enable; 1=write, 0=read; stable while req high
address[0..1]  in  2xADDR_WIDTH  per-port address; stable while req high
wdata[0..1]  in  2xDATA_WIDTH  per-port write data; stable while req high
ack[1:0]  out  2  per-port acknowledge
rdata  out  DATA_WIDTH  read data for the acked port; valid while its ack is high
ram_write  out  1  to RAM write; RAM stores on its rising edge
ram_write_address  out  ADDR_WIDTH  to RAM write_address
ram_read_address  out  ADDR_WIDTH  to RAM read_address
ram_data_in  out  DATA_WIDTH  to RAM data_in
ram_data_out  in  DATA_WIDTH  from RAM data_out
ram_req  out  1  to RAM req_prev
ram_ack  in  1  from RAM ack_prev; asynchronous, always synchronised

Behaviour:
- Reset (async, reset_n=0): FSM goes to IDLE. ack, ram_write and ram_req are 0. Addresses, ram_data_in and rdata are 0. last_grant is 1, so port 0 wins the first contention.
- FSM states: IDLE, GRANT, SETUP, READ_REQ, READ_REL, WR_PULSE, WR_HOLD, RESP.
- IDLE: if any req is high, select a port, register its we/address/wdata, and go to GRANT. Round robin: with both requesting, grant the port != last_grant. Update last_grant on grant.
- GRANT: drive ram_read_address or ram_write_address, plus ram_data_in, from the registered fields. Go to SETUP.
- SETUP: one cycle of address/data setup at the RAM. Then go to WR_PULSE if we, else READ_REQ.
- READ_REQ: ram_req=1. Wait until synced ram_ack=1. On exit, capture ram_data_out into rdata and go to READ_REL.
- READ_REL: ram_req=0. Wait until synced ram_ack=0, then go to RESP.
- WR_PULSE: ram_write=1 for exactly WRITE_PULSE_CYCLES cycles. Go to WR_HOLD.
- WR_HOLD: ram_write=0; address and data held one more cycle. Go to RESP.
- RESP: ack[granted]=1. Wait for req[granted]=0. Then ack=0 and return to IDLE in the same edge.
- Latency, counted from the edge where IDLE samples req high to the edge where ack rises:
  - read: 4+2*SYNC_STAGES cycles (8 at default)
  - write: 3+WRITE_PULSE_CYCLES cycles (4 at default)
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- Only one ack is high at a time, and only for the granted port. The non-granted port waits; its req is neither lost nor re-ordered.
- Address outputs and ram_data_in change only in GRANT. They are stable throughout the RAM strobes.
- Requester drops req before ack (protocol violation): the RAM operation still completes. RESP then sees req low, so ack pulses for one cycle and the FSM returns to IDLE.
- New req on the granted port while in RESP (req never dropped): treated as the same transaction. No re-issue occurs until req drops and rises again.
- Reset mid-operation: all outputs drop immediately.
  - A write whose ram_write rising edge already occurred has been stored.
  - A read in progress is abandoned; rdata is cleared.

Optional Feature:
RAM_ARB_FIXED_PRIORITY_EN
- Defined: port 0 always wins contention and last_grant is unused. Port 1 is served only when req[0] is low in IDLE.
- Undefined: round robin as above.

Decomposition:
- Package ram_arb_pkg holds:
  - state_t enum for the FSM states
  - PORT_CPU=0 and PORT_LOADER=1 constants
  - NUM_PORTS=2
- Sub-module ram_ack_sync: SYNC_STAGES-deep flop chain with async reset to 0. It is instantiated once for ram_ack.

Test Plan:
- Port 0 writes 0xA5 to address 0x10 -> ram_write is high for 1 cycle with ram_write_address=0x10 and ram_data_in=0xA5, and ack[0] rises 4 cycles after req is sampled. A RAM model holds 0xA5.
- Port 1 reads address 0x10 after that write -> ram_req pulses, and ack[1] rises 8 cycles after req with rdata=0xA5.
- Both ports request reads in the same cycle, repeated 4 times -> grants alternate 0,1,0,1. With RAM_ARB_FIXED_PRIORITY_EN defined, all grants go to 0 while req[0] is held.
- Port 0 drops req 2 cycles into a read -> the read completes, ack[0] is high for exactly 1 cycle, and the FSM returns to IDLE.
- reset_n is asserted during READ_REQ -> ram_req, ack and rdata are 0 immediately. After release, a port-1 read of 0x10 returns 0xA5.
- ram_ack model delayed by 5 cycles -> ack[1] is correspondingly delayed, with no extra ram_req edge and no data corruption.
